// File: rtl/tap_delay_detector_pkg.sv
// Shared types and constants for the tap delay detector.
// The detector tells which tap (0..3 register stages) of the delay line is in use.
package tap_delay_detector_pkg;

    typedef enum logic {SEARCH, LOCKED} state_e;

    localparam int TAPS   = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/tap_delay_detector_if.sv
// Stream and status bundle between the delay-line receive side and the detector.
// The master drives the streams and the clear; the slave returns lock status and the aligned byte.
interface tap_delay_detector_if;
    import tap_delay_detector_pkg::*;

    logic       clear;
    logic       in_valid;
    data_t      d_ref;
    data_t      d_dly;
    logic       locked;
    logic [1:0] sel_est;
    logic       lock_lost;
    data_t      aligned_q;

    modport master (
        output clear, in_valid, d_ref, d_dly,
        input  locked, sel_est, lock_lost, aligned_q
    );

    modport slave (
        input  clear, in_valid, d_ref, d_dly,
        output locked, sel_est, lock_lost, aligned_q
    );

endinterface

// File: rtl/tap_delay_detector_tap_match_counter.sv
// Saturating counter of consecutive valid beats on which one tap equals the delayed stream.
// The next count is exported so that lock is decided on the edge that samples the final match.
module tap_match_counter
    import tap_delay_detector_pkg::*;
#(
    parameter int LOCK_COUNT = 4
) (
    input  logic clk,
    input  logic areset,
    input  logic clear,
    input  logic valid,
    input  logic eligible,
    input  logic match,
    output cnt_t cnt_next
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    // NOTE: cnt_d gets a default before any branch, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (valid) begin
            if (eligible && match) begin
                cnt_d = (cnt_q == CNT_W'(LOCK_COUNT)) ? cnt_q : cnt_q + cnt_t'(1);
            end else begin
                cnt_d = '0;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_next = cnt_d;

endmodule

// File: rtl/tap_delay_detector.sv
// Finds which tap of the reference history aligns with the delayed stream, holds lock
// until LOSS_COUNT consecutive misses, and outputs the aligned reference byte.
module tap_delay_detector
    import tap_delay_detector_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2
) (
    input logic                  clk,
    input logic                  areset,
    tap_delay_detector_if.slave  bus
);

    state_e     state_q, state_d;
    data_t      h1_q, h2_q, h3_q, h1_d, h2_d, h3_d;
    logic [1:0] fill_q, fill_d;
    cnt_t       miss_q, miss_d;
    logic [1:0] sel_q, sel_d;
    logic       lock_lost_q, lock_lost_d;
    data_t      aligned_q, aligned_d;

    data_t      tap [TAPS];
    logic       eligible [TAPS];
    cnt_t       cnt_next [TAPS];
    logic       drop;
    logic       lock_hit;
    logic [1:0] lock_k;

    always_comb begin
        tap[0] = bus.d_ref;
        tap[1] = h1_q;
        tap[2] = h2_q;
        tap[3] = h3_q;
        eligible[0] = 1'b1;
        eligible[1] = (fill_q != 2'd0);
        eligible[2] = fill_q[1];
        eligible[3] = (fill_q == 2'd3);
    end

    // A loss of lock also restarts every match counter, so search begins from scratch.
    for (genvar k = 0; k < TAPS; k++) begin : g_cnt
        tap_match_counter #(.LOCK_COUNT(LOCK_COUNT)) u_cnt (
            .clk      (clk),
            .areset   (areset),
            .clear    (bus.clear | drop),
            .valid    (bus.in_valid),
            .eligible (eligible[k]),
            .match    (bus.d_dly == tap[k]),
            .cnt_next (cnt_next[k])
        );
    end

    always_comb begin
        miss_d = miss_q;
        drop   = 1'b0;
        if (bus.clear) begin
            miss_d = '0;
        end else if (state_q == LOCKED && bus.in_valid) begin
            miss_d = (bus.d_dly == tap[sel_q]) ? '0 : miss_q + cnt_t'(1);
            if (miss_d == CNT_W'(LOSS_COUNT)) begin
                drop   = 1'b1;
                miss_d = '0;
            end
        end
    end

    // Scanning downward leaves the lowest matching tap, so a constant stream reports delay 0.
    always_comb begin
        lock_hit = 1'b0;
        lock_k   = '0;
        for (int k = TAPS - 1; k >= 0; k--) begin
            if (cnt_next[k] == CNT_W'(LOCK_COUNT)) begin
                lock_hit = 1'b1;
                lock_k   = 2'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        h1_d        = h1_q;
        h2_d        = h2_q;
        h3_d        = h3_q;
        fill_d      = fill_q;
        sel_d       = sel_q;
        aligned_d   = aligned_q;
        lock_lost_d = 1'b0;
        if (bus.clear) begin
            state_d   = SEARCH;
            h1_d      = '0;
            h2_d      = '0;
            h3_d      = '0;
            fill_d    = '0;
            sel_d     = '0;
            aligned_d = '0;
        end else if (bus.in_valid) begin
            h1_d   = bus.d_ref;
            h2_d   = h1_q;
            h3_d   = h2_q;
            fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
            case (state_q)
                SEARCH: begin
                    if (lock_hit) begin
                        state_d   = LOCKED;
                        sel_d     = lock_k;
                        aligned_d = tap[lock_k];
                    end
                end
                LOCKED: begin
                    if (drop) begin
                        state_d     = SEARCH;
                        lock_lost_d = 1'b1;
                        aligned_d   = '0;
                    end else begin
                        aligned_d = tap[sel_q];
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // NOTE: the three history bytes are ordinary flops and take the reset too.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= SEARCH;
            h1_q        <= '0;
            h2_q        <= '0;
            h3_q        <= '0;
            fill_q      <= '0;
            miss_q      <= '0;
            sel_q       <= '0;
            lock_lost_q <= 1'b0;
            aligned_q   <= '0;
        end else begin
            state_q     <= state_d;
            h1_q        <= h1_d;
            h2_q        <= h2_d;
            h3_q        <= h3_d;
            fill_q      <= fill_d;
            miss_q      <= miss_d;
            sel_q       <= sel_d;
            lock_lost_q <= lock_lost_d;
            aligned_q   <= aligned_d;
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.sel_est   = sel_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.aligned_q = aligned_q;

endmodule

// File: tb/tb_tap_delay_detector.sv
// Bench for tap_delay_detector: directed lock/loss/reset scenarios plus randomized streams,
// all compared against a queue-based model of the detection rules.
module tb_tap_delay_detector;
    import tap_delay_detector_pkg::*;

    localparam int LOCK_COUNT = 4;
    localparam int LOSS_COUNT = 2;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    tap_delay_detector_if bus ();

    tap_delay_detector #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Model: valid d_ref bytes since reset/clear, and per-tap run lengths of matches.
    logic [7:0] m_hist [$];
    int         m_run [4];
    bit         m_locked;
    int         m_sel;
    int         m_miss;
    logic [7:0] m_aligned;
    bit         m_lost;

    function automatic void model_reset();
        m_hist.delete();
        foreach (m_run[k]) m_run[k] = 0;
        m_locked  = 1'b0;
        m_sel     = 0;
        m_miss    = 0;
        m_aligned = 8'h00;
        m_lost    = 1'b0;
    endfunction

    function automatic void model_step(bit v, bit clr, logic [7:0] r, logic [7:0] d);
        logic [7:0] taps [4];
        bit         elig [4];
        m_lost = 1'b0;
        if (clr) begin
            model_reset();
            return;
        end
        if (!v) return;
        for (int k = 0; k < 4; k++) begin
            elig[k] = (k == 0) || (m_hist.size() >= k);
            taps[k] = (k == 0) ? r : (elig[k] ? m_hist[m_hist.size() - k] : 8'h00);
            if (elig[k] && d == taps[k])
                m_run[k] = (m_run[k] >= LOCK_COUNT) ? LOCK_COUNT : m_run[k] + 1;
            else
                m_run[k] = 0;
        end
        if (m_locked) begin
            m_miss = (d == taps[m_sel]) ? 0 : m_miss + 1;
            if (m_miss == LOSS_COUNT) begin
                m_locked  = 1'b0;
                m_lost    = 1'b1;
                m_aligned = 8'h00;
                m_miss    = 0;
                foreach (m_run[k]) m_run[k] = 0;
            end else begin
                m_aligned = taps[m_sel];
            end
        end else begin
            for (int k = 3; k >= 0; k--) begin
                if (m_run[k] == LOCK_COUNT) begin
                    m_locked  = 1'b1;
                    m_sel     = k;
                    m_aligned = taps[k];
                end
            end
        end
        m_hist.push_back(r);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
    endfunction

    function automatic logic [11:0] obs();
        return {bus.locked, bus.locked ? bus.sel_est : 2'b00, bus.lock_lost, bus.aligned_q};
    endfunction

    function automatic logic [11:0] expv();
        return {m_locked, m_locked ? 2'(m_sel) : 2'b00, m_lost, m_aligned};
    endfunction

    task automatic step(input bit v, input logic [7:0] r, input logic [7:0] d, input bit clr = 1'b0);
        @(negedge clk);
        bus.in_valid = v;
        bus.d_ref    = r;
        bus.d_dly    = d;
        bus.clear    = clr;
        @(posedge clk);
        model_step(v, clr, r, d);
        #1;
    endtask

    task automatic test_reset();
        areset       = 1'b1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.d_ref    = 8'h00;
        bus.d_dly    = 8'h00;
        model_reset();
        #12;
        vectors++;
        if ({bus.locked, bus.sel_est, bus.lock_lost, bus.aligned_q} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected 000",
                     {bus.locked, bus.sel_est, bus.lock_lost, bus.aligned_q});
        end
        areset = 1'b0;
    endtask

    // Stream d_ref=n with d_dly delayed by dly valid beats; optional idle beat before each valid one.
    task automatic test_delay(input int dly, input bit gaps);
        logic [7:0] d;
        step(1'b1, 8'($urandom), 8'($urandom), 1'b1);
        vectors++;
        if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL delay%0d_clear: got %h expected %h", dly, obs(), expv());
        end
        for (int n = 0; n < dly + 10; n++) begin
            if (gaps) begin
                step(1'b0, 8'($urandom), 8'($urandom));
                vectors++;
                if (obs() !== expv()) begin
                    miscompares++;
                    $display("FAIL delay%0d_gap n=%0d: got %h expected %h", dly, n, obs(), expv());
                end
            end
            d = (n >= dly) ? 8'(n - dly) : 8'hFF;
            step(1'b1, 8'(n), d);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL delay%0d_model n=%0d: got %h expected %h", dly, n, obs(), expv());
            end
            if (n == dly + 2) begin
                vectors++;
                if (bus.locked !== 1'b0) begin
                    miscompares++;
                    $display("FAIL delay%0d_early_lock n=%0d: got locked=%b expected 0", dly, n, bus.locked);
                end
            end
            if (n == dly + 3) begin
                vectors++;
                if ({bus.locked, bus.sel_est} !== {1'b1, 2'(dly)}) begin
                    miscompares++;
                    $display("FAIL delay%0d_lock_edge: got locked=%b sel=%0d expected 1/%0d",
                             dly, bus.locked, bus.sel_est, dly);
                end
            end
            if (n > dly + 3) begin
                vectors++;
                if (bus.aligned_q !== d) begin
                    miscompares++;
                    $display("FAIL delay%0d_aligned n=%0d: got %h expected %h", dly, n, bus.aligned_q, d);
                end
            end
        end
    endtask

    task automatic lock_delay1(output int n_out);
        step(1'b1, 8'h00, 8'h00, 1'b1);
        for (int n = 0; n < 6; n++) step(1'b1, 8'(n), (n >= 1) ? 8'(n - 1) : 8'hFF);
        n_out = 6;
    endtask

    task automatic test_loss();
        int n;
        lock_delay1(n);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'(n), 8'(n - 1) ^ 8'h80);
            n++;
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL loss_corrupt%0d: got %h expected %h", i, obs(), expv());
            end
        end
        vectors++;
        if ({bus.locked, bus.lock_lost, bus.aligned_q} !== {1'b0, 1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL loss_drop: got locked=%b lost=%b aligned=%h expected 0/1/00",
                     bus.locked, bus.lock_lost, bus.aligned_q);
        end
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'(n), 8'(n - 1));
            n++;
            vectors++;
            if (bus.lock_lost !== 1'b0 || bus.locked !== (i == 4) ||
                (i == 4 && bus.sel_est !== 2'd1)) begin
                miscompares++;
                $display("FAIL loss_relock beat=%0d: got locked=%b lost=%b sel=%0d",
                         i, bus.locked, bus.lock_lost, bus.sel_est);
            end
        end
    endtask

    task automatic test_glitch();
        int n;
        lock_delay1(n);
        step(1'b1, 8'(n), 8'(n - 1) ^ 8'h80);
        n++;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({bus.locked, bus.lock_lost} !== 2'b10 || obs() !== expv()) begin
                miscompares++;
                $display("FAIL glitch beat=%0d: got locked=%b lost=%b expected 1/0",
                         i, bus.locked, bus.lock_lost);
            end
            step(1'b1, 8'(n), 8'(n - 1));
            n++;
        end
    endtask

    task automatic test_constant();
        step(1'b1, 8'hA5, 8'hA5, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 8'hA5, 8'hA5);
        vectors++;
        if ({bus.locked, bus.sel_est, bus.aligned_q} !== {1'b1, 2'd0, 8'hA5}) begin
            miscompares++;
            $display("FAIL constant_priority: got locked=%b sel=%0d aligned=%h expected 1/0/a5",
                     bus.locked, bus.sel_est, bus.aligned_q);
        end
    endtask

    task automatic test_areset();
        int n;
        lock_delay1(n);
        #1 areset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if ({bus.locked, bus.sel_est, bus.lock_lost, bus.aligned_q} !== 12'h000) begin
            miscompares++;
            $display("FAIL areset_async: got %h expected 000",
                     {bus.locked, bus.sel_est, bus.lock_lost, bus.aligned_q});
        end
        #1 areset = 1'b0;
        step(1'b1, 8'(n), 8'(n - 1));
        vectors++;
        if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL areset_after: got %h expected %h", obs(), expv());
        end
    endtask

    task automatic test_clear();
        int n;
        lock_delay1(n);
        step(1'b1, 8'(n), 8'(n - 1), 1'b1);
        n++;
        vectors++;
        if ({bus.locked, bus.lock_lost, bus.aligned_q} !== 10'h000) begin
            miscompares++;
            $display("FAIL clear_drop: got locked=%b lost=%b aligned=%h expected 0/0/00",
                     bus.locked, bus.lock_lost, bus.aligned_q);
        end
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 8'(n), 8'(n - 1));
            n++;
            vectors++;
            if (bus.locked !== (i == 5) || obs() !== expv()) begin
                miscompares++;
                $display("FAIL clear_relock beat=%0d: got locked=%b expected %b", i, bus.locked, i == 5);
            end
        end
    endtask

    // Random bytes, random delay per segment, idle beats, corruption and occasional clears.
    task automatic test_random();
        logic [7:0] sent [$];
        logic [7:0] r, d;
        int dly;
        bit v, clr;
        for (int seg = 0; seg < 8; seg++) begin
            dly = $urandom_range(0, 3);
            for (int i = 0; i < 60; i++) begin
                v   = ($urandom_range(0, 3) != 0);
                clr = ($urandom_range(0, 99) == 0);
                r   = 8'($urandom);
                d   = 8'($urandom);
                if (v) begin
                    sent.push_back(r);
                    if (sent.size() > dly) d = sent[sent.size() - 1 - dly];
                    if ($urandom_range(0, 11) == 0) d = d ^ 8'($urandom_range(1, 255));
                    if (sent.size() > 8) void'(sent.pop_front());
                end
                step(v, r, d, clr);
                vectors++;
                if (obs() !== expv()) begin
                    miscompares++;
                    $display("FAIL random seg=%0d i=%0d: got %h expected %h", seg, i, obs(), expv());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_delay(2, 1'b0);
        test_delay(0, 1'b0);
        test_delay(3, 1'b0);
        test_delay(2, 1'b1);
        test_loss();
        test_glitch();
        test_constant();
        test_areset();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
